rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that sits directly upstream of the 4-to-2 encoder. It turns up to four concurrent request lines into a registered, strictly one-hot grant vector plus a matching 2-bit index. Each grant is held until the consumer signals completion, the requester drops its request, or a timeout expires. The one-hot output is guaranteed never to be multi-hot, so the downstream encoder always sees a legal input.

---
 rtl/rr_arbiter_4_pkg.sv | 13 +
 rtl/rr_arbiter_4_pick4.sv | 28 ++
 rtl/rr_arbiter_4.sv | 116 +++++++++++
 tb/tb_rr_arbiter_4.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// State encoding, requester count and index width.
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_4_pick4.sv
// Rotating first-one search for the round-robin arbiter.
// Rotates req by ptr, finds the lowest set bit, and un-rotates it.
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // rotate so ptr lands at bit 0, then take the lowest set bit
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    win_idx = off + ptr;
    win     = (|req) ? (N_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Grants are held until done, request drop, or timeout.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             to_hit;
  logic             drop;
  logic             rel;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign drop   = !req[idx_q];
  assign rel    = done || drop || to_hit;

  // state and output registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   if (rel)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values for grant, pointer, counter and pulse
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          gnt_d   = win;
          idx_d   = win_idx;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = idx_q + 1'b1;
          to_d    = to_hit && !done && !drop;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with TIMEOUT=4.
// Vector table plus timeout and async-reset sequences.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int tests;
  int fails;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_4 #(
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [3:0] eg, logic [1:0] ei,
                         logic ev, logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(ev));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] r, logic d, logic [3:0] g,
                              logic [1:0] i, logic t);
    vec_t v;
    v.req  = r;
    v.done = d;
    v.gnt  = g;
    v.idx  = i;
    v.to   = t;
    return v;
  endfunction

  // invariant: gnt is zero or one-hot and agrees with gnt_idx/gnt_valid
  always @(negedge clk) begin
    logic [1:0] enc;
    enc = 2'd0;
    for (int k = 0; k < 4; k++) if (gnt[k]) enc = 2'(k);
    chk("inv.onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("inv.idx", 32'(gnt_idx), 32'(enc));
    chk("inv.valid", 32'(gnt_valid), 32'(|gnt));
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // single request, then rotation from ptr 3, wrap, ignored inputs
    vecs.push_back(mk(4'b0100, 0, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(4'b0100, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1111, 0, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1111, 0, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1111, 0, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1111, 0, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1111, 0, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(4'b1111, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1001, 0, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(4'b1001, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b1001, 0, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(4'b1001, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b0000, 1, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b0100, 0, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(4'b0111, 0, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(4'b0011, 0, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(4'b0011, 0, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(4'b0011, 1, 4'b0000, 2'd0, 0));

    tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx,
              |vecs[i].gnt, vecs[i].to);
    end
    done = 1'b0;

    // timeout: ptr is 1, lone requester 1 held for TIMEOUT cycles
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out($sformatf("to_hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_rel", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    req = 4'b0110;
    tick();
    chk_out("to_rel2", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("to_next", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done lands on the timeout cycle: single release, no pulse
    for (int c = 0; c < 3; c++) tick();
    chk_out("to_last", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_out("to_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;

    // async reset mid-grant on requester 3 (ptr is 3)
    req = 4'b1000;
    tick();
    chk_out("ar_gnt", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010;
    tick();
    chk_out("ar_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk_out("ar_first", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_out("ar_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
